// File: rtl/crossbar_permute.sv
// Parametrised register bank with crossbar feedback: individual loads from a shared bus,
// then a start-triggered sequencer applies rotate/reverse/swap a programmable number of times.
module crossbar_permute #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    parameter int unsigned ADDRW = 2,
    parameter int unsigned CNTW  = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] Data,
    input  logic [NREG-1:0]  RinExt,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [CNTW-1:0]  Count,
    input  logic [ADDRW-1:0] SelA,
    input  logic [ADDRW-1:0] SelB,
    input  logic [ADDRW-1:0] RdAddr,
    output logic [WIDTH-1:0] RdData,
    output logic             Busy,
    output logic             Done
);

    localparam logic [1:0] MODE_ROT_UP = 2'b00;
    localparam logic [1:0] MODE_ROT_DN = 2'b01;
    localparam logic [1:0] MODE_REV    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ADDRW-1:0] sel_a_q, sel_a_d;
    logic [ADDRW-1:0] sel_b_q, sel_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] regs_cur [NREG];
    logic [WIDTH-1:0] val_a, val_b;
    logic             hit_a, hit_b, swap_ok;

    // Swap operands; an out-of-range or identical index pair disables the swap.
    always_comb begin
        val_a = '0;
        val_b = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (sel_a_q == ADDRW'(i)) begin
                val_a = regs_cur[i];
                hit_a = 1'b1;
            end
            if (sel_b_q == ADDRW'(i)) begin
                val_b = regs_cur[i];
                hit_b = 1'b1;
            end
        end
        swap_ok = hit_a && hit_b && (sel_a_q != sel_b_q);
    end

    always_comb begin
        RdData = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (RdAddr == ADDRW'(i)) begin
                RdData = regs_cur[i];
            end
        end
    end

    // Per-register next value: bus load in IDLE, one permutation step per RUN cycle.
    for (genvar gi = 0; gi < int'(NREG); gi++) begin : g_reg
        localparam int unsigned PREV_IDX = (gi + NREG - 1) % NREG;
        localparam int unsigned NEXT_IDX = (gi + 1) % NREG;
        localparam int unsigned MIR_IDX  = NREG - 1 - gi;
        localparam logic [ADDRW-1:0] MY_ADDR = ADDRW'(gi);

        logic [WIDTH-1:0] r_q, r_d;

        assign regs_cur[gi] = r_q;

        always_comb begin
            r_d = r_q;
            case (state_q)
                S_IDLE: begin
                    if (RinExt[gi]) begin
                        r_d = Data;
                    end
                end
                S_RUN: begin
                    case (mode_q)
                        MODE_ROT_UP: r_d = regs_cur[PREV_IDX];
                        MODE_ROT_DN: r_d = regs_cur[NEXT_IDX];
                        MODE_REV:    r_d = regs_cur[MIR_IDX];
                        default: begin
                            if (swap_ok && (sel_a_q == MY_ADDR)) begin
                                r_d = val_b;
                            end else if (swap_ok && (sel_b_q == MY_ADDR)) begin
                                r_d = val_a;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end

        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                r_q <= '0;
            end else begin
                r_q <= r_d;
            end
        end
    end

    // Sequencer next state and latched command.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d  = Mode;
                    cnt_d   = Count;
                    sel_a_d = SelA;
                    sel_b_d = SelB;
                    state_d = (Count != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_crossbar_permute.sv
// Scoreboard bench for crossbar_permute: stimulus queues per-cycle expectations, a negedge
// monitor pops them and sweeps the read port. Second instance covers WIDTH=16, NREG=3.
module tb_crossbar_permute;

    typedef struct {
        int          cyc;
        bit          dut;
        bit          busy;
        bit          done;
        logic [63:0] regs;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [7:0]  Data = '0;
    logic [3:0]  RinExt = '0;
    logic        Start = 1'b0;
    logic [1:0]  Mode = '0;
    logic [2:0]  Count = '0;
    logic [1:0]  SelA = '0;
    logic [1:0]  SelB = '0;
    logic [1:0]  RdAddr = '0;
    logic [7:0]  RdData;
    logic        Busy, Done;

    logic [15:0] Data3 = '0;
    logic [2:0]  RinExt3 = '0;
    logic        Start3 = 1'b0;
    logic [15:0] RdData3;
    logic        Busy3, Done3;

    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [63:0] tr[$];

    crossbar_permute #(.WIDTH(8), .NREG(4), .ADDRW(2), .CNTW(3)) dut (
        .Clock(Clock), .Resetn(Resetn), .Data(Data), .RinExt(RinExt), .Start(Start),
        .Mode(Mode), .Count(Count), .SelA(SelA), .SelB(SelB), .RdAddr(RdAddr),
        .RdData(RdData), .Busy(Busy), .Done(Done)
    );

    crossbar_permute #(.WIDTH(16), .NREG(3), .ADDRW(2), .CNTW(3)) dut3 (
        .Clock(Clock), .Resetn(Resetn), .Data(Data3), .RinExt(RinExt3), .Start(Start3),
        .Mode(Mode), .Count(Count), .SelA(SelA), .SelB(SelB), .RdAddr(RdAddr),
        .RdData(RdData3), .Busy(Busy3), .Done(Done3)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare handshake and full register contents on the scheduled cycle.
    always @(negedge Clock) begin
        exp_t        e;
        bit          hit;
        logic [15:0] got, want;
        hit = 1'b0;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_entry", 16'(sb[0].cyc), 16'(cyc));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            hit = 1'b1;
            chk(e.dut ? "busy3" : "busy", 16'(e.dut ? Busy3 : Busy), 16'(e.busy));
            chk(e.dut ? "done3" : "done", 16'(e.dut ? Done3 : Done), 16'(e.done));
            for (int a = 0; a < 4; a++) begin
                RdAddr = 2'(a);
                #1;
                if (e.dut) begin
                    got  = RdData3;
                    want = (a < 3) ? e.regs[a*16 +: 16] : 16'h0000;
                end else begin
                    got  = {8'h00, RdData};
                    want = {8'h00, e.regs[a*8 +: 8]};
                end
                chk(e.dut ? "rd3" : "rd", got, want);
            end
        end
        if (Done) chk("unexpected_done", 16'(hit && !e.dut && e.done), 16'(1));
        if (Done3) chk("unexpected_done3", 16'(hit && e.dut && e.done), 16'(1));
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_now(input bit d, input bit b, input bit dn, input logic [63:0] r);
        sb.push_back('{cyc, d, b, dn, r});
    endtask

    task automatic load4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            RinExt = 4'(1 << i);
            Data   = v[i*8 +: 8];
            tick();
        end
        RinExt = '0;
        expect_now(1'b0, 1'b0, 1'b0, {32'h0, v});
        tick();
    endtask

    task automatic load3(input logic [47:0] v);
        for (int i = 0; i < 3; i++) begin
            RinExt3 = 3'(1 << i);
            Data3   = v[i*16 +: 16];
            tick();
        end
        RinExt3 = '0;
        expect_now(1'b1, 1'b0, 1'b0, {16'h0, v});
        tick();
    endtask

    // tr[j] holds the contents after j applications; tr must have c+1 entries.
    task automatic run_seq(input bit d, input logic [1:0] m, input logic [2:0] c,
                           input logic [1:0] a, input logic [1:0] b,
                           input bit inj, input bit ld0);
        automatic int s = cyc;
        Mode = m;
        Count = c;
        SelA = a;
        SelB = b;
        if (d) Start3 = 1'b1;
        else Start = 1'b1;
        if (ld0) begin
            RinExt = 4'b0001;
            Data   = 8'hAA;
        end
        for (int j = 1; j <= int'(c); j++) sb.push_back('{s + j, d, 1'b1, 1'b0, tr[j-1]});
        sb.push_back('{s + int'(c) + 1, d, 1'b1, 1'b1, tr[c]});
        sb.push_back('{s + int'(c) + 2, d, 1'b0, 1'b0, tr[c]});
        tick();
        Start = 1'b0;
        Start3 = 1'b0;
        RinExt = '0;
        if (inj) begin
            Start  = 1'b1;
            RinExt = 4'hF;
            Data   = 8'hEE;
            Mode   = 2'b10;
            Count  = 3'd1;
        end
        tick();
        Start = 1'b0;
        RinExt = '0;
        repeat (int'(c) + 1) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at time %0t", $time);
        $fatal(1);
    end

    initial begin
        automatic int s;
        tick();
        expect_now(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        expect_now(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        Resetn = 1'b1;
        tick();

        // Reset in the middle of a rotate sequence.
        load4(32'h44332211);
        s = cyc;
        Mode = 2'b00;
        Count = 3'd6;
        Start = 1'b1;
        sb.push_back('{s + 1, 1'b0, 1'b1, 1'b0, 64'h44332211});
        tick();
        Start = 1'b0;
        tick();
        Resetn = 1'b0;
        expect_now(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        Resetn = 1'b1;
        expect_now(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        load4(32'h44332211);
        tr = '{64'h44332211, 64'h33221144};
        run_seq(1'b0, 2'b00, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        tr = '{64'h33221144, 64'h22114433, 64'h11443322, 64'h44332211, 64'h33221144};
        run_seq(1'b0, 2'b00, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0);

        load4(32'h44332211);
        tr = '{64'h44332211, 64'h11443322, 64'h22114433, 64'h33221144};
        run_seq(1'b0, 2'b01, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0);

        load4(32'h44332211);
        tr = '{64'h44332211, 64'h11223344};
        run_seq(1'b0, 2'b10, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        tr = '{64'h11223344, 64'h44332211, 64'h11223344};
        run_seq(1'b0, 2'b10, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0);

        load4(32'h44332211);
        tr = '{64'h44332211, 64'h11332244};
        run_seq(1'b0, 2'b11, 3'd1, 2'd0, 2'd3, 1'b0, 1'b0);
        tr = '{64'h11332244, 64'h11332244};
        run_seq(1'b0, 2'b11, 3'd1, 2'd2, 2'd2, 1'b0, 1'b0);
        tr = '{64'h11332244};
        run_seq(1'b0, 2'b11, 3'd0, 2'd0, 2'd3, 1'b0, 1'b0);

        // Start and loads during RUN are ignored.
        tr = '{64'h11332244, 64'h33224411, 64'h22441133};
        run_seq(1'b0, 2'b00, 3'd2, 2'd0, 2'd0, 1'b1, 1'b0);

        // Load and Start in the same IDLE cycle.
        tr = '{64'h224411AA, 64'h4411AA22};
        run_seq(1'b0, 2'b00, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1);

        // Three-register, 16-bit instance.
        load3(48'h333322221111);
        tr = '{64'h333322221111, 64'h111122223333};
        run_seq(1'b1, 2'b10, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        tr = '{64'h111122223333, 64'h111122223333};
        run_seq(1'b1, 2'b11, 3'd1, 2'd0, 2'd3, 1'b0, 1'b0);
        tr = '{64'h111122223333, 64'h333311112222};
        run_seq(1'b1, 2'b01, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0);

        repeat (3) tick();
        chk("scoreboard_drained", 16'(sb.size()), 16'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/crossbar_permute.md
Name: crossbar_permute

Overview:
Parametrised register bank with a full crossbar feedback path. It is the successor to the fixed 4-register, 8-bit swap datapath. Registers are loaded individually from a shared Data bus. A start-triggered sequencer then applies a selected permutation (rotate up, rotate down, reverse, or pairwise swap) a programmable number of times, one application per clock, with Busy/Done handshake. It sits beside the bus datapath as a scratch/permutation unit; contents are read back through a combinational read port.

Parameters:
WIDTH, 8, data width of each register
NREG, 4, number of registers (2..16)
ADDRW, 2, address width; NREG <= 2**ADDRW
CNTW, 3, width of the repeat-count input

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Data  input  WIDTH  external load data
RinExt  input  NREG  per-register load enables (bit i -> R[i])
Start  input  1  start a permutation sequence (sampled in IDLE only)
Mode  input  2  00 rotate up, 01 rotate down, 10 reverse, 11 swap pair
Count  input  CNTW  number of permutation applications
SelA  input  ADDRW  first register index for swap mode
SelB  input  ADDRW  second register index for swap mode
RdAddr  input  ADDRW  read-back register index
RdData  output  WIDTH  combinational R[RdAddr]; 0 if RdAddr >= NREG
Busy  output  1  sequence in progress
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (Resetn=0, async): all R[i]=0, FSM=IDLE, Busy=0, Done=0, latched mode/count/selects cleared. Reset mid-sequence aborts it immediately; no Done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Busy=0, Done=0.
  - For each i with RinExt[i]=1, R[i] <= Data at the edge. Multiple bits set load the same Data.
  - Start=1 latches Mode, Count, SelA, SelB into internal registers.
  - Next state is RUN if Count != 0, else FIN.
  - If Start and RinExt are both active in the same cycle, the load still happens; the permutation operates on the loaded values from the next cycle.
- RUN:
  - Busy=1.
  - Each cycle applies the latched permutation once to all registers simultaneously, using old values on the right-hand side, and decrements the remaining count.
  - On the cycle the remaining count reaches 0, next state is FIN.
  - RinExt and Start are ignored.
- FIN: Busy=1, Done=1 for exactly one cycle; next state is IDLE. RinExt and Start are ignored.
- Latency: Start sampled at edge k → RUN during cycles k+1..k+Count → Done high in cycle k+Count+1 → Busy falls at edge k+Count+2. With Count=0: FIN in cycle k+1, no register change.
- Permutations, per application, i in 0..NREG-1:
  - rotate up: R[(i+1) mod NREG] <= R[i].
  - rotate down: R[i] <= R[(i+1) mod NREG].
  - reverse: R[i] <= R[NREG-1-i]; middle register unchanged for odd NREG.
  - swap: R[A] <= R[B], R[B] <= R[A], all others hold. A==B, or either index >= NREG → all hold; the sequence still runs and Done still pulses.
- Wrap: rotate applied NREG times restores the original contents. Reverse or swap applied an even number of times restores the original contents.
- Start while Busy=1 is ignored. Inputs other than RdAddr are don't-care outside IDLE.
- RdData is valid in every state, including mid-sequence; it shows the current register contents.

Test Plan:
- Reset/load: assert Resetn=0 mid-RUN → RdData=0 for all addresses, Busy=0, Done=0. Then load 0x11,0x22,0x33,0x44 via RinExt=0001,0010,0100,1000 → readback matches.
- Rotate up: contents 11,22,33,44; Mode=00, Count=1 → R=44,11,22,33; Done pulses 2 cycles after Start. Count=4 → original restored, Busy high for 5 cycles.
- Rotate down and reverse:
  - Mode=01, Count=3 on 11,22,33,44 → 22,33,44,11 ... expected per-application result must be checked each cycle; final value equals rotate up once (44,11,22,33).
  - Mode=10, Count=1 → 44,33,22,11; Count=2 → unchanged.
- Swap: SelA=0, SelB=3, Count=1 → 44,22,33,11. SelA=SelB=2 → unchanged with Done pulse. Count=0 → Done in cycle k+1, no change.
- Handshake corners:
  - Start plus RinExt during RUN → ignored, data unchanged by the load.
  - Start plus RinExt[0] with Data=0xAA in IDLE (rotate up, Count=1) → R[1]=0xAA after the sequence.
  - Parametrisation: WIDTH=16, NREG=3, ADDRW=2; RdAddr=3 → 0; reverse keeps R[1].
